pc_sequencer: RTL and testbench
===============================

// Module: pc_sequencer
// PURPOSE
//   Owns the fetch program counter and decides its next value every cycle.
//   Sources: sequential increment, stall hold, branch/jump redirect from EX, halt/resume.
//   Sits between the hazard/branch units and instruction memory.
//   Drives the fetch address plus the valid/flush strobes for the IF/ID and ID/EX registers.
// PARAMETERS
//   PC_W      6  PC / instruction-address width in bits
//   INC       4  byte increment per sequential fetch
//   FLUSH_CYC 2  bubble cycles after a redirect; legal range 1..7
//   RST_PC    0  PC value loaded on reset
// PORTS
//   clk           in   1     system clock, rising edge
//   rst           in   1     asynchronous reset, active-high
//   stall_req     in   1     load-use hazard: hold PC and block the IF/ID load
//   redir_valid   in   1     taken branch or jump resolved in EX this cycle
//   redir_target  in   PC_W  redirect address, used verbatim with no alignment check
//   halt_req      in   1     ecall/ebreak seen; level, held by the requester
//   resume        in   1     single-cycle pulse that leaves HALT
//   pc_out        out  PC_W  current fetch address (registered)
//   fetch_valid   out  1     high when the instruction at pc_out may enter IF/ID
//   flush         out  1     kill IF/ID and ID/EX contents this cycle
//   state_out     out  2     debug: current state encoding
// BEHAVIOUR
//   State
//   - Registers: pc_q, state_q, cnt_q (3 bits).
//   - All outputs decode from registers only: no combinational path from inputs to outputs.
//   - Encodings: RUN=0, STALL=1, FLUSH=2, HALT=3.
//   - fetch_valid = (state==RUN); flush = (state==FLUSH); pc_out = pc_q.
//   Reset
//   - While rst is high: pc_q=RST_PC, state=RUN, cnt_q=0.
//   - Hence fetch_valid=1, flush=0, state_out=0.
//   - Reset acts immediately, including mid-FLUSH or mid-HALT.
//   Transitions, at each posedge
//   - RUN, priority redir > halt > stall > advance:
//       redir_valid: pc=target, state=FLUSH, cnt=FLUSH_CYC-1.
//       halt_req:    state=HALT, pc held.
//       stall_req:   state=STALL, pc held.
//       else:        pc=pc+INC.
//   - STALL: pc held, fetch_valid=0.
//       redir_valid: same as in RUN.
//       halt_req:    HALT.
//       stall_req:   stay in STALL.
//       else:        RUN with pc unchanged, so the same address is re-fetched.
//   - FLUSH: pc held at the target.
//       halt_req and stall_req are ignored.
//       redir_valid: pc=new target, cnt=FLUSH_CYC-1 (restart).
//       cnt==0:      RUN.
//       else:        cnt=cnt-1.
//       Net effect: flush is high for exactly FLUSH_CYC cycles, then the target is fetched.
//   - HALT: pc held, fetch_valid=0.
//       redir_valid and stall_req are ignored.
//       resume: RUN with pc=pc+INC, i.e. the instruction after the halting one.
//   Timing and arithmetic
//   - Latency: input sampled at edge N is visible on pc_out/fetch_valid/flush after edge N.
//   - PC arithmetic is modulo 2^PC_W (PC_W=6, INC=4: 60 -> 0). Overflow is silent.
//   Simultaneous events
//   - redir_valid with halt_req in RUN/STALL: redirect wins.
//   - halt_req is re-evaluated once RUN is reached.
// TESTING
//   1. Reset, then idle inputs for 17 cycles:
//      pc_out 0,4,8,...,60,0 (wrap); fetch_valid=1 throughout; flush=0.
//   2. At pc=8, stall_req high for 3 cycles:
//      pc_out stays 8 for 3 cycles with fetch_valid=0; then pc_out 8 (valid=1), then 12.
//   3. At pc=12, redir_valid with target=40 (FLUSH_CYC=2):
//      flush=1 for 2 cycles at pc_out=40, fetch_valid=0; then pc_out 40 with valid=1, then 44.
//   4. Redirect during STALL, and a second redirect during FLUSH:
//      last target wins; flush is held 2 cycles from the last redirect.
//   5. halt_req at pc=20, then resume 4 cycles later:
//      pc_out=20 with fetch_valid=0 and state_out=3 until resume; then 24 with valid=1.
//      redir_valid during HALT has no effect.
//   6. Assert rst mid-FLUSH, off-edge:
//      pc_out=0, flush=0, fetch_valid=1 immediately, with no clock edge needed.

Source files
------------

// File: rtl/pc_sequencer.sv
// pc_sequencer: owns the fetch program counter. Each cycle it picks the next
// PC from sequential increment, stall hold, EX redirect or halt/resume, and
// drives the fetch address plus the IF/ID valid and pipeline flush strobes.
// Every output decodes from registers only.
module pc_sequencer #(
    parameter int PC_W      = 6,
    parameter int INC       = 4,
    parameter int FLUSH_CYC = 2,   // legal range 1..7
    parameter int RST_PC    = 0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            stall_req,
    input  logic            redir_valid,
    input  logic [PC_W-1:0] redir_target,
    input  logic            halt_req,
    input  logic            resume,
    output logic [PC_W-1:0] pc_out,
    output logic            fetch_valid,
    output logic            flush,
    output logic [1:0]      state_out
);

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        STALL = 2'd1,
        FLUSH = 2'd2,
        HALT  = 2'd3
    } state_t;

    localparam logic [PC_W-1:0] INC_V    = PC_W'(INC);
    localparam logic [PC_W-1:0] RST_PC_V = PC_W'(RST_PC);
    // Loaded on a redirect so that flush stays high for FLUSH_CYC cycles.
    localparam logic [2:0]      CNT_INIT = 3'(FLUSH_CYC - 1);

    state_t          state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic [2:0]      cnt_q, cnt_d;

    // State, PC and flush counter registers; reset acts without a clock edge.
    // NOTE: sequential state uses non-blocking (<=) so every register samples
    // pre-edge values; blocking here would create order-dependent races.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= RUN;
            pc_q    <= RST_PC_V;
            cnt_q   <= 3'd0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state and next-PC selection; PC arithmetic wraps modulo 2^PC_W.
    // NOTE: defaults are assigned first so no path leaves a variable
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            RUN, STALL: begin
                if (redir_valid) begin
                    state_d = FLUSH;
                    pc_d    = redir_target;
                    cnt_d   = CNT_INIT;
                end else if (halt_req) begin
                    state_d = HALT;
                end else if (stall_req) begin
                    state_d = STALL;
                end else if (state_q == RUN) begin
                    pc_d = pc_q + INC_V;
                end else begin
                    // Leaving STALL re-fetches the held address.
                    state_d = RUN;
                end
            end
            FLUSH: begin
                // halt_req and stall_req are deliberately ignored here.
                if (redir_valid) begin
                    pc_d  = redir_target;
                    cnt_d = CNT_INIT;
                end else if (cnt_q == 3'd0) begin
                    state_d = RUN;
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end
            HALT: begin
                // Resume continues with the instruction after the halting one.
                if (resume) begin
                    state_d = RUN;
                    pc_d    = pc_q + INC_V;
                end
            end
            default: state_d = RUN;
        endcase
    end

    assign pc_out      = pc_q;
    assign fetch_valid = (state_q == RUN);
    assign flush       = (state_q == FLUSH);
    assign state_out   = state_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: directed bench for pc_sequencer with hand-computed
// expectations for the default parameters (PC_W=6, INC=4, FLUSH_CYC=2).
module tb_pc_sequencer;

    logic       clk;
    logic       rst;
    logic       stall_req;
    logic       redir_valid;
    logic [5:0] redir_target;
    logic       halt_req;
    logic       resume;
    logic [5:0] pc_out;
    logic       fetch_valid;
    logic       flush;
    logic [1:0] state_out;

    int total = 0;
    int bad   = 0;

    pc_sequencer dut (
        .clk          (clk),
        .rst          (rst),
        .stall_req    (stall_req),
        .redir_valid  (redir_valid),
        .redir_target (redir_target),
        .halt_req     (halt_req),
        .resume       (resume),
        .pc_out       (pc_out),
        .fetch_valid  (fetch_valid),
        .flush        (flush),
        .state_out    (state_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Compare all outputs against one expected tuple.
    task automatic expect_out(input string tag, input logic [5:0] pc,
                              input logic fv, input logic fl, input logic [1:0] st);
        check({tag, ".pc"},    {2'b00, pc_out},      {2'b00, pc});
        check({tag, ".valid"}, {7'd0, fetch_valid},  {7'd0, fv});
        check({tag, ".flush"}, {7'd0, flush},        {7'd0, fl});
        check({tag, ".state"}, {6'd0, state_out},    {6'd0, st});
    endtask

    // Advance one rising edge and settle just after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst          = 1'b1;
        stall_req    = 1'b0;
        redir_valid  = 1'b0;
        redir_target = 6'd0;
        halt_req     = 1'b0;
        resume       = 1'b0;

        // 1. Reset state, then free-running increment with wrap 60 -> 0.
        #1;
        expect_out("reset", 6'd0, 1'b1, 1'b0, 2'd0);
        #1 rst = 1'b0;
        for (int i = 1; i <= 16; i++) begin
            step();
            check($sformatf("seq%0d.pc", i), {2'b00, pc_out}, 8'((4 * i) % 64));
            check($sformatf("seq%0d.valid", i), {7'd0, fetch_valid}, 8'd1);
        end
        expect_out("wrap", 6'd0, 1'b1, 1'b0, 2'd0);
        step();
        step();
        expect_out("pre_stall", 6'd8, 1'b1, 1'b0, 2'd0);

        // 2. Three-cycle stall at pc=8, then re-fetch 8, then 12.
        stall_req = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            expect_out($sformatf("stall%0d", i), 6'd8, 1'b0, 1'b0, 2'd1);
        end
        stall_req = 1'b0;
        step();
        expect_out("stall_exit", 6'd8, 1'b1, 1'b0, 2'd0);
        step();
        expect_out("stall_next", 6'd12, 1'b1, 1'b0, 2'd0);

        // 3. Redirect at pc=12 to 40: two flush cycles, then 40, then 44.
        redir_valid  = 1'b1;
        redir_target = 6'd40;
        step();
        redir_valid = 1'b0;
        expect_out("redir_f0", 6'd40, 1'b0, 1'b1, 2'd2);
        step();
        expect_out("redir_f1", 6'd40, 1'b0, 1'b1, 2'd2);
        step();
        expect_out("redir_tgt", 6'd40, 1'b1, 1'b0, 2'd0);
        step();
        expect_out("redir_next", 6'd44, 1'b1, 1'b0, 2'd0);

        // 4. Redirect out of STALL, then a second redirect during FLUSH.
        stall_req = 1'b1;
        step();
        expect_out("r4_stall", 6'd44, 1'b0, 1'b0, 2'd1);
        redir_valid  = 1'b1;
        redir_target = 6'd16;
        step();
        expect_out("r4_first", 6'd16, 1'b0, 1'b1, 2'd2);
        redir_target = 6'd32;
        step();
        redir_valid = 1'b0;
        stall_req   = 1'b0;
        expect_out("r4_second", 6'd32, 1'b0, 1'b1, 2'd2);
        step();
        expect_out("r4_f1", 6'd32, 1'b0, 1'b1, 2'd2);
        step();
        expect_out("r4_tgt", 6'd32, 1'b1, 1'b0, 2'd0);
        step();
        expect_out("r4_next", 6'd36, 1'b1, 1'b0, 2'd0);

        // Move to pc=20 via a redirect.
        redir_valid  = 1'b1;
        redir_target = 6'd20;
        step();
        redir_valid = 1'b0;
        step();
        step();
        expect_out("to20", 6'd20, 1'b1, 1'b0, 2'd0);

        // 5. Halt at pc=20; a redirect during HALT is ignored; resume -> 24.
        halt_req = 1'b1;
        step();
        expect_out("halt0", 6'd20, 1'b0, 1'b0, 2'd3);
        redir_valid  = 1'b1;
        redir_target = 6'd8;
        step();
        redir_valid = 1'b0;
        expect_out("halt_redir", 6'd20, 1'b0, 1'b0, 2'd3);
        step();
        expect_out("halt2", 6'd20, 1'b0, 1'b0, 2'd3);
        halt_req = 1'b0;
        resume   = 1'b1;
        step();
        resume = 1'b0;
        expect_out("resume", 6'd24, 1'b1, 1'b0, 2'd0);

        // Redirect beats a simultaneous halt; halt is taken once RUN returns.
        halt_req     = 1'b1;
        redir_valid  = 1'b1;
        redir_target = 6'd48;
        step();
        redir_valid = 1'b0;
        expect_out("rh_flush", 6'd48, 1'b0, 1'b1, 2'd2);
        step();
        expect_out("rh_f1", 6'd48, 1'b0, 1'b1, 2'd2);
        step();
        expect_out("rh_run", 6'd48, 1'b1, 1'b0, 2'd0);
        step();
        expect_out("rh_halt", 6'd48, 1'b0, 1'b0, 2'd3);
        halt_req = 1'b0;
        resume   = 1'b1;
        step();
        resume = 1'b0;
        expect_out("rh_resume", 6'd52, 1'b1, 1'b0, 2'd0);

        // 6. Asynchronous reset mid-FLUSH, away from any clock edge.
        redir_valid  = 1'b1;
        redir_target = 6'd28;
        step();
        redir_valid = 1'b0;
        expect_out("pre_rst", 6'd28, 1'b0, 1'b1, 2'd2);
        #2 rst = 1'b1;
        #1;
        expect_out("async_rst", 6'd0, 1'b1, 1'b0, 2'd0);
        step();
        expect_out("rst_held", 6'd0, 1'b1, 1'b0, 2'd0);
        #2 rst = 1'b0;
        step();
        expect_out("post_rst", 6'd4, 1'b1, 1'b0, 2'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
